// File: rtl/care_actions.sv
// Care buttons -> one clipped stat update request per press, then a global cooldown.
// Optional macro CARE_SIDE_EFFECT_EN adds a hygiene +1 side request after each feed.
module care_actions #(
  parameter int unsigned TICK_DIV       = 10_000_000,
  parameter int unsigned COOLDOWN_TICKS = 3,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  inputs,
  input  logic [3:0]  random,
  input  logic [23:0] stat_levels,
  output logic        req_valid,
  output logic [2:0]  req_sel,
  output logic        req_sub,
  output logic [3:0]  req_amount,
  input  logic        req_ready,
  output logic        busy,
  output logic        refused,
  output logic        timeout
);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_TICKS - 1);

`ifdef CARE_SIDE_EFFECT_EN
  typedef enum logic [1:0] {IDLE, REQ, SIDE, COOLDOWN} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, COOLDOWN} state_t;
`endif

  state_t          state_q, state_d;
  logic [5:0]      sync1_q, sync2_q, prev_q, press;
  logic [TW-1:0]   tick_q;
  logic            tick;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CW-1:0]   cd_q, cd_d;
  logic [2:0]      sel_q, sel_d, sel_c;
  logic            sub_q, sub_d, hit_c;
  logic [3:0]      amt_q, amt_d, amt_c, lvl_c, base_c;
  logic            refused_q, refused_d, timeout_q, timeout_d;
  logic            unused_bits;

  assign unused_bits = ^{inputs[7:6], random[3:2]};
  assign press = sync2_q & ~prev_q;
  assign tick  = (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      tick_q  <= '0;
    end else begin
      sync1_q <= inputs[5:0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= tick ? '0 : tick_q + 1'b1;
    end
  end

  // Lowest-numbered press wins; the clip against the current level keeps the stat from underflowing.
  always_comb begin
    sel_c  = '0;
    hit_c  = 1'b0;
    lvl_c  = '0;
    base_c = '0;
    for (int i = 5; i >= 0; i--) begin
      if (press[i]) begin
        sel_c = 3'(i);
        hit_c = 1'b1;
      end
    end
    case (sel_c)
      3'd0: begin lvl_c = stat_levels[3:0];   base_c = 4'd3; end
      3'd1: begin lvl_c = stat_levels[7:4];   base_c = 4'd1 + {2'b00, random[1:0]}; end
      3'd2: begin lvl_c = stat_levels[11:8];  base_c = 4'd4; end
      3'd3: begin lvl_c = stat_levels[15:12]; base_c = 4'd15; end
      3'd4: begin lvl_c = stat_levels[19:16]; base_c = 4'd15; end
      3'd5: begin lvl_c = stat_levels[23:20]; base_c = 4'd2; end
      default: begin lvl_c = '0; base_c = '0; end
    endcase
    amt_c = (base_c < lvl_c) ? base_c : lvl_c;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sub_d     = sub_q;
    amt_d     = amt_q;
    wait_d    = wait_q;
    cd_d      = cd_q;
    timeout_d = 1'b0;
    refused_d = (state_q != IDLE) && (|press);
    case (state_q)
      IDLE: begin
        if (hit_c) begin
          if (lvl_c == 4'd0) begin
            refused_d = 1'b1;
          end else begin
            sel_d   = sel_c;
            sub_d   = 1'b1;
            amt_d   = amt_c;
            wait_d  = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          state_d = COOLDOWN;
          cd_d    = '0;
`ifdef CARE_SIDE_EFFECT_EN
          if (sel_q == 3'd0 && stat_levels[15:12] != 4'hF) begin
            state_d = SIDE;
            sel_d   = 3'd3;
            sub_d   = 1'b0;
            amt_d   = 4'd1;
            wait_d  = '0;
          end
`endif
        end else if (wait_q == WAIT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`ifdef CARE_SIDE_EFFECT_EN
      SIDE: begin
        // A lost side request still costs the player a cooldown.
        if (req_ready || wait_q == WAIT_LAST) begin
          state_d   = COOLDOWN;
          cd_d      = '0;
          timeout_d = !req_ready;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`endif
      COOLDOWN: begin
        if (tick) begin
          if (cd_q == CD_LAST) state_d = IDLE;
          else                 cd_d    = cd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      sub_q     <= 1'b0;
      amt_q     <= '0;
      wait_q    <= '0;
      cd_q      <= '0;
      refused_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sub_q     <= sub_d;
      amt_q     <= amt_d;
      wait_q    <= wait_d;
      cd_q      <= cd_d;
      refused_q <= refused_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef CARE_SIDE_EFFECT_EN
  assign req_valid = (state_q == REQ) || (state_q == SIDE);
`else
  assign req_valid = (state_q == REQ);
`endif
  assign busy       = (state_q != IDLE);
  assign req_sel    = sel_q;
  assign req_sub    = sub_q;
  assign req_amount = amt_q;
  assign refused    = refused_q;
  assign timeout    = timeout_q;
endmodule
